// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: host configuration/handshake and DDS drive signals of the sweep sequencer
interface dds_sweep_ctrl_if #(
   parameter int phase_width = 4,
   parameter int dwell_width = 16
);
   logic                   i_start;
   logic                   i_abort;
   logic [1:0]             i_mode;
   logic [phase_width-1:0] i_f_start;
   logic [phase_width-1:0] i_f_stop;
   logic [phase_width-1:0] i_f_step;
   logic [dwell_width-1:0] i_dwell;
   logic [1:0]             i_ctrl_in;
   logic [phase_width-1:0] o_phase_incr;
   logic [1:0]             o_control;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_step_strobe;
   logic                   o_sweep_dir;
   modport master (
      output i_start, i_abort, i_mode, i_f_start, i_f_stop, i_f_step, i_dwell, i_ctrl_in,
      input  o_phase_incr, o_control, o_busy, o_done, o_step_strobe, o_sweep_dir
   );
   modport slave (
      input  i_start, i_abort, i_mode, i_f_start, i_f_stop, i_f_step, i_dwell, i_ctrl_in,
      output o_phase_incr, o_control, o_busy, o_done, o_step_strobe, o_sweep_dir
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS phase increment from start to stop with a per-value dwell
module dds_sweep_ctrl #(
   parameter int phase_width = 4,
   parameter int dwell_width = 16
) (
   input logic             clk,
   input logic             rst,
   dds_sweep_ctrl_if.slave bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   logic [0:0]             r_state;
   logic [1:0]             r_mode;
   logic [phase_width-1:0] r_f_start;
   logic [phase_width-1:0] r_f_stop;
   logic [phase_width-1:0] r_step;
   logic [dwell_width-1:0] r_dwell;
   logic [phase_width-1:0] r_target;
   logic [dwell_width-1:0] r_cnt;
   logic [phase_width-1:0] r_incr;
   logic [1:0]             r_ctrl;
   logic                   r_dir;
   logic                   r_done;
   logic                   r_strobe;
   logic                   w_leg_end;
   logic                   w_tri;
   logic                   w_single;
   logic                   w_dir_nx;
   logic [phase_width-1:0] w_tgt_nx;
   logic [phase_width:0]   w_sum;
   logic [phase_width:0]   w_diff;
   logic [phase_width-1:0] w_up;
   logic [phase_width-1:0] w_dn;
   logic [phase_width-1:0] w_next;
   // next value toward the (possibly just swapped) leg target, clamped and computed one bit wider
   always_comb begin
      w_leg_end = r_incr == r_target;
      w_tri     = r_mode == 2'd2;
      w_single  = r_mode != 2'd1 && r_mode != 2'd2;
      w_tgt_nx  = (w_leg_end && w_tri) ? ((r_target == r_f_stop) ? r_f_start : r_f_stop) : r_target;
      w_dir_nx  = (w_leg_end && w_tri) ? ~r_dir : r_dir;
      w_sum     = {1'b0, r_incr} + {1'b0, r_step};
      w_diff    = {1'b0, r_incr} - {1'b0, r_step};
      w_up      = (w_sum > {1'b0, w_tgt_nx}) ? w_tgt_nx : w_sum[phase_width-1:0];
      w_dn      = (w_diff[phase_width] || w_diff < {1'b0, w_tgt_nx}) ? w_tgt_nx : w_diff[phase_width-1:0];
      w_next    = w_dir_nx ? w_dn : w_up;
   end
   // sweep sequencer: abort beats start, dwell countdown, leg-end handling per mode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_mode    <= '0;
         r_f_start <= '0;
         r_f_stop  <= '0;
         r_step    <= '0;
         r_dwell   <= '0;
         r_target  <= '0;
         r_cnt     <= '0;
         r_incr    <= '0;
         r_ctrl    <= '0;
         r_dir     <= 1'b0;
         r_done    <= 1'b0;
         r_strobe  <= 1'b0;
      end else if (bus.i_abort) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_incr   <= '0;
         r_ctrl   <= '0;
         r_dir    <= 1'b0;
         r_done   <= 1'b0;
         r_strobe <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_done   <= 1'b0;
         r_strobe <= bus.i_start;
         if (bus.i_start) begin
            r_state   <= ST_RUN;
            r_mode    <= bus.i_mode;
            r_f_start <= bus.i_f_start;
            r_f_stop  <= bus.i_f_stop;
            r_step    <= (bus.i_f_step == '0) ? phase_width'(1) : bus.i_f_step;
            r_dwell   <= bus.i_dwell;
            r_target  <= bus.i_f_stop;
            r_cnt     <= bus.i_dwell;
            r_incr    <= bus.i_f_start;
            r_ctrl    <= bus.i_ctrl_in;
            r_dir     <= bus.i_f_stop < bus.i_f_start;
         end
      end else if (r_cnt != '0) begin
         r_cnt    <= r_cnt - dwell_width'(1);
         r_strobe <= 1'b0;
      end else if (w_leg_end && w_single) begin
         r_state  <= ST_IDLE;
         r_done   <= 1'b1;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= 1'b1;
         r_cnt    <= r_dwell;
         r_target <= w_tgt_nx;
         r_dir    <= w_dir_nx;
         r_incr   <= (w_leg_end && r_mode == 2'd1) ? r_f_start : w_next;
      end
   end
   assign bus.o_phase_incr  = r_incr;
   assign bus.o_control     = r_ctrl;
   assign bus.o_busy        = r_state == ST_RUN;
   assign bus.o_done        = r_done;
   assign bus.o_step_strobe = r_strobe;
   assign bus.o_sweep_dir   = r_dir;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed and random sweeps scored against a value-list reference model
module tb_dds_sweep_ctrl;
   localparam int PW = 4;
   localparam int DW = 16;
   typedef struct packed {
      logic [PW-1:0] incr;
      logic [1:0]    ctrl;
      logic          busy;
      logic          done;
      logic          strobe;
      logic          dir;
   } exp_t;
   typedef int iq_t[$];
   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   exp_t m;
   exp_t e_exp;
   exp_t e_act;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sv[$];
   bit sd[$];
   int m_c;
   int m_d;
   bit m_single;
   dds_sweep_ctrl_if #(.phase_width(PW), .dwell_width(DW)) bus();
   dds_sweep_ctrl #(.phase_width(PW), .dwell_width(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   // values visited walking from a to b in steps of st, clamping at b
   function automatic iq_t make_leg(input int a, input int b, input int st);
      iq_t l;
      int v = a;
      l.push_back(v);
      while (v != b) begin
         v = (b > v) ? ((v + st > b) ? b : v + st) : ((v - st < b) ? b : v - st);
         l.push_back(v);
      end
      return l;
   endfunction
   function automatic void push(input int v, input bit d);
      sv.push_back(v);
      sd.push_back(d);
   endfunction
   // full list of (value, direction) the sweep presents, one entry per dwell period
   function automatic void model_start(input int md, input int fs, input int fe, input int st);
      iq_t l1;
      iq_t l2;
      bit d0 = fe < fs;
      int s = (st == 0) ? 1 : st;
      l1 = make_leg(fs, fe, s);
      l2 = make_leg(fe, fs, s);
      sv = {};
      sd = {};
      m_single = md == 0 || md == 3;
      foreach (l1[i]) push(l1[i], d0);
      if (!m_single) begin
         while (sv.size() < 400) begin
            if (md == 1) foreach (l1[i]) push(l1[i], d0);
            else if (fs == fe) push(fs, !sd[sd.size()-1]);
            else begin
               for (int i = 1; i < l2.size(); i++) push(l2[i], !d0);
               for (int i = 1; i < l1.size(); i++) push(l1[i], d0);
            end
         end
      end
   endfunction
   function automatic void model_cycle(input bit r, input bit st, input bit ab, input int md,
                                       input int fs, input int fe, input int stp, input int dw, input int ci);
      int p;
      if (r) m = '0;
      else if (ab) m = '0;
      else if (!m.busy) begin
         m.done = 1'b0;
         m.strobe = 1'b0;
         if (st) begin
            model_start(md, fs, fe, stp);
            m_d = dw;
            m_c = 0;
            m.busy = 1'b1;
            m.strobe = 1'b1;
            m.ctrl = 2'(ci);
            m.incr = PW'(sv[0]);
            m.dir = sd[0];
         end
      end else begin
         m_c++;
         p = m_c / (m_d + 1);
         if (m_single && p == sv.size()) begin
            m.busy = 1'b0;
            m.done = 1'b1;
            m.strobe = 1'b0;
         end else begin
            m.incr = PW'(sv[p]);
            m.dir = sd[p];
            m.strobe = (m_c % (m_d + 1)) == 0;
         end
      end
   endfunction
   task automatic step(input bit r, input bit st, input bit ab, input int md,
                       input int fs, input int fe, input int stp, input int dw, input int ci);
      rst = r;
      bus.i_start = st;
      bus.i_abort = ab;
      bus.i_mode = 2'(md);
      bus.i_f_start = PW'(fs);
      bus.i_f_stop = PW'(fe);
      bus.i_f_step = PW'(stp);
      bus.i_dwell = DW'(dw);
      bus.i_ctrl_in = 2'(ci);
      model_cycle(r, st, ab, md, fs, fe, stp, dw, ci);
      @(posedge clk);
      q.push_back(m);
      #1;
   endtask
   task automatic go(input int md, input int fs, input int fe, input int stp, input int dw, input int ci);
      step(0, 1, 0, md, fs, fe, stp, dw, ci);
   endtask
   task automatic junk(input bit r, input bit st, input bit ab);
      step(r, st, ab, $urandom_range(3), $urandom_range(15), $urandom_range(15),
           $urandom_range(15), $urandom_range(3), $urandom_range(3));
   endtask
   task automatic run(input int n, input bit allow_start);
      for (int i = 0; i < n; i++) junk(0, allow_start && ($urandom_range(7) == 0), 0);
   endtask
   // scoreboard: one expected record per clock, compared mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e_exp = q.pop_front();
         e_act = {bus.o_phase_incr, bus.o_control, bus.o_busy, bus.o_done, bus.o_step_strobe, bus.o_sweep_dir};
         checks++;
         if (e_act !== e_exp) begin
            errors++;
            $display("FAIL cycle %0d: got incr=%0d ctrl=%0d busy=%0b done=%0b strobe=%0b dir=%0b, expected incr=%0d ctrl=%0d busy=%0b done=%0b strobe=%0b dir=%0b",
                     cyc, e_act.incr, e_act.ctrl, e_act.busy, e_act.done, e_act.strobe, e_act.dir,
                     e_exp.incr, e_exp.ctrl, e_exp.busy, e_exp.done, e_exp.strobe, e_exp.dir);
         end
         cyc++;
      end
   end
   initial begin
      m = '0;
      junk(1, 0, 0);
      junk(1, 1, 0);
      run(2, 0);
      go(0, 2, 10, 3, 1, 3);
      run(12, 0);
      go(0, 12, 1, 5, 0, 2);
      run(6, 0);
      go(2, 0, 6, 2, 0, 1);
      run(20, 1);
      junk(0, 0, 1);
      go(1, 1, 15, 7, 2, 2);
      run(10, 1);
      junk(0, 0, 1);
      run(3, 0);
      step(0, 1, 1, 0, 4, 8, 1, 0, 3);
      run(3, 0);
      go(0, 3, 5, 0, 0, 1);
      run(5, 0);
      go(0, 9, 9, 4, 3, 2);
      run(7, 0);
      junk(0, 0, 1);
      go(2, 0, 6, 2, 0, 1);
      run(7, 0);
      junk(1, 0, 0);
      go(2, 0, 6, 2, 0, 1);
      run(10, 0);
      junk(0, 0, 1);
      repeat (60) begin
         go($urandom_range(3), $urandom_range(15), $urandom_range(15), $urandom_range(7),
            $urandom_range(3), $urandom_range(3));
         run($urandom_range(1, 60), $urandom_range(1));
         junk($urandom_range(3) == 0, $urandom_range(1), 1);
         run(2, 0);
      end
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected records left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
